// File: rtl/rx_pkg.sv
// Command bytes, receive FSM states and enables bit positions shared by the receive and
// transmit controllers.
package rx_pkg;

    localparam logic [7:0] CmdWriteA = 8'h01;
    localparam logic [7:0] CmdWriteB = 8'h02;
    localparam logic [7:0] CmdRead   = 8'h03;
    localparam logic [7:0] CmdSum    = 8'h04;
    localparam logic [7:0] CmdAvg    = 8'h05;
    localparam logic [7:0] CmdEuc    = 8'h06;
    localparam logic [7:0] CmdMan    = 8'h07;
    localparam logic [7:0] CmdDot    = 8'h08;

    localparam int unsigned NumOps = 6;
    localparam int unsigned EnRead = 0;
    localparam int unsigned EnSum  = 1;
    localparam int unsigned EnAvg  = 2;
    localparam int unsigned EnEuc  = 3;
    localparam int unsigned EnMan  = 4;
    localparam int unsigned EnDot  = 5;

    typedef enum logic [2:0] {
        StIdle,
        StRxLo,
        StRxHi,
        StWrite,
        StOpWait
    } rx_state_e;

    // One-hot start pulse for an operation command; zero for anything else.
    function automatic logic [NumOps-1:0] cmd_to_enable(input logic [7:0] cmd);
        logic [NumOps-1:0] en;
        en = '0;
        case (cmd)
            CmdRead: en[EnRead] = 1'b1;
            CmdSum:  en[EnSum]  = 1'b1;
            CmdAvg:  en[EnAvg]  = 1'b1;
            CmdEuc:  en[EnEuc]  = 1'b1;
            CmdMan:  en[EnMan]  = 1'b1;
            CmdDot:  en[EnDot]  = 1'b1;
            default: en = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Holds the low byte of an element and forms the element word once the high byte arrives.
module byte_assembler #(
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lo_en,
    input  logic [7:0]        rx_data,
    output logic [DATA_W-1:0] word
);

    logic [7:0] lo_q, lo_d;

    always_comb begin
        lo_d = lo_q;
        if (lo_en) begin
            lo_d = rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_q <= '0;
        end else begin
            lo_q <= lo_d;
        end
    end

    // Current byte is the high half; upper bits beyond DATA_W are discarded.
    assign word = DATA_W'({rx_data, lo_q});

endmodule

// File: rtl/data_receive.sv
// Command decoder and vector loader fed by a UART byte stream.
// Optional macro RX_TIMEOUT_EN adds an inter-byte timeout inside a write frame.
module data_receive
    import rx_pkg::*;
#(
    parameter int unsigned N_ELEMS     = 1024,
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 10_000_000,
    localparam int unsigned AW         = $clog2(N_ELEMS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              op_done,
    output logic              mem_we_a,
    output logic              mem_we_b,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [5:0]        enables,
    output logic              busy,
    output logic              err
);

    rx_state_e         state_q, state_d;
    logic              tgt_b_q, tgt_b_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_a_q, we_a_d;
    logic              we_b_q, we_b_d;
    logic [5:0]        en_q, en_d;
    logic              err_q, err_d;
    logic              lo_en;
    logic [DATA_W-1:0] word;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    byte_assembler #(
        .DATA_W (DATA_W)
    ) u_byte_assembler (
        .clk     (clk),
        .reset   (reset),
        .lo_en   (lo_en),
        .rx_data (rx_data),
        .word    (word)
    );

    always_comb begin
        state_d = state_q;
        tgt_b_d = tgt_b_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_a_d  = 1'b0;
        we_b_d  = 1'b0;
        en_d    = '0;
        err_d   = 1'b0;
        lo_en   = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_ready) begin
                    if (rx_data == CmdWriteA || rx_data == CmdWriteB) begin
                        tgt_b_d = (rx_data == CmdWriteB);
                        addr_d  = '0;
                        state_d = StRxLo;
                    end else if (rx_data >= CmdRead && rx_data <= CmdDot) begin
                        en_d    = cmd_to_enable(rx_data);
                        state_d = StOpWait;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRxLo: begin
                if (rx_ready) begin
                    lo_en   = 1'b1;
                    state_d = StRxHi;
                end
            end
            StRxHi: begin
                if (rx_ready) begin
                    wdata_d = word;
                    we_a_d  = !tgt_b_q;
                    we_b_d  = tgt_b_q;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // The strobe is high for this one cycle; the address moves only afterwards.
                if (addr_q == AW'(N_ELEMS - 1)) begin
                    addr_d  = '0;
                    state_d = StIdle;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = StRxLo;
                end
            end
            StOpWait: begin
                if (rx_ready) begin
                    err_d = 1'b1;
                end
                if (op_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef RX_TIMEOUT_EN
        tmo_d = '0;
        if ((state_q == StRxLo || state_q == StRxHi) && !rx_ready) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                addr_d  = '0;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            tgt_b_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_a_q  <= 1'b0;
            we_b_q  <= 1'b0;
            en_q    <= '0;
            err_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tgt_b_q <= tgt_b_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_a_q  <= we_a_d;
            we_b_q  <= we_b_d;
            en_q    <= en_d;
            err_q   <= err_d;
`ifdef RX_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign mem_we_a  = we_a_q;
    assign mem_we_b  = we_b_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign enables   = en_q;
    assign err       = err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/data_receive.md
DATA_RECEIVE -- requirements
Module: data_receive

Interface
REQ-001 SHALL have parameter N_ELEMS, default 1024, number of elements per vector.
REQ-002 SHALL have parameter DATA_W, default 10, stored element width in bits (1..16).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 10_000_000, idle cycles tolerated between bytes of one frame.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8, byte from the UART receiver.
REQ-007 SHALL have port rx_ready, input, 1, one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port op_done, input, 1, operation-complete strobe from the compute/transmit side.
REQ-009 SHALL have port mem_we_a / mem_we_b, output, 1 each, write strobes for vector memories A and B.
REQ-010 SHALL have port mem_addr, output, $clog2(N_ELEMS), element write address.
REQ-011 SHALL have port mem_wdata, output, DATA_W, element write data.
REQ-012 SHALL have port enables, output, 6, {dot, man, euc, avg, sum, read} one-hot start pulse.
REQ-013 SHALL have ports busy (frame or operation in progress) and err (one-cycle protocol-error pulse), output, 1 each.

Function
REQ-014 SHALL decode command bytes: 0x01 write A, 0x02 write B, 0x03 read, 0x04 sum, 0x05 avg, 0x06 euc, 0x07 man, 0x08 dot.
REQ-015 SHALL implement states IDLE, RX_LO, RX_HI, WRITE, OP_WAIT.
REQ-016 IDLE: on rx_ready with 0x01/0x02 SHALL latch target, clear mem_addr, go RX_LO.
REQ-017 IDLE: on rx_ready with 0x03..0x08 SHALL pulse matching enables bit exactly one cycle (cycle after the strobe) and go OP_WAIT.
REQ-018 IDLE: any other byte SHALL pulse err one cycle and stay IDLE.
REQ-019 RX_LO: on rx_ready SHALL store low byte, go RX_HI; RX_HI: on rx_ready SHALL form {hi,lo}[DATA_W-1:0] on mem_wdata, go WRITE.
REQ-020 WRITE SHALL assert the selected mem_we_* for exactly one cycle with stable mem_addr/mem_wdata, then increment mem_addr and return to RX_LO.
REQ-021 Write after mem_addr = N_ELEMS-1 SHALL return to IDLE with mem_addr = 0; no wrap into a second vector.
REQ-022 OP_WAIT SHALL return to IDLE on op_done; rx_ready in OP_WAIT SHALL drop the byte and pulse err.
REQ-023 op_done and rx_ready in the same OP_WAIT cycle SHALL go IDLE, drop the byte, pulse err.
REQ-024 op_done outside OP_WAIT SHALL be ignored.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 At most one enables bit and at most one mem_we_* SHALL be high in any cycle.

Reset
REQ-027 reset low SHALL immediately force IDLE, mem_addr=0, mem_wdata=0, mem_we_a=mem_we_b=0, enables=0, busy=0, err=0, timeout counter=0.
REQ-028 Reset mid-frame SHALL abandon the frame; already-written elements are not rolled back.

Configuration
REQ-029 With RX_TIMEOUT_EN defined: in RX_LO/RX_HI, TIMEOUT_CYC consecutive cycles without rx_ready SHALL pulse err, return to IDLE, clear mem_addr; counter clears on every rx_ready.
REQ-030 Without RX_TIMEOUT_EN: no counter SHALL be synthesized; RX_LO/RX_HI wait indefinitely.

Structure
REQ-031 Package rx_pkg SHALL hold the command-byte constants, state enum, and enables bit-index constants shared with the transmit controller.
REQ-032 Byte-pair assembly (RX_LO/RX_HI latching) SHALL be a sub-module named byte_assembler.

Verification
REQ-033 Reset, then 0x05 -> enables=6'b000100 for one cycle, busy=1; op_done -> busy=0 next cycle.
REQ-034 N_ELEMS=4: 0x01,0x34,0x02,0x78,0x01,0xFF,0x03,0x00,0x00 -> mem_we_a writes 0x234@0, 0x178@1, 0x3FF@2, 0x000@3; then IDLE, busy=0.
REQ-035 0x02 then 8 pairs with N_ELEMS=4 -> four mem_we_b writes, then second byte group decoded as commands (0x00 -> err).
REQ-036 0x09 in IDLE -> err one cycle, no enables, no writes.
REQ-037 RX_TIMEOUT_EN, TIMEOUT_CYC=100: 0x01,0x10 then 100 silent cycles -> err pulse, IDLE, mem_addr=0, no write.
REQ-038 0x08 then rx_ready with 0x01 coincident with op_done -> IDLE, err pulse, no write-A frame started.
